// File: rtl/load_writeback_buffer.sv
// Load return buffer: tracks in-flight loads in issue order, captures the
// returning bus words and hands extracted/extended results to the register
// file write port through a valid/ready handshake.
module load_writeback_buffer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int LANE_W = $clog2(DATA_W / 8)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [2:0]             req_op,
   input  logic [LANE_W-1:0]      req_lane,
   input  logic [4:0]             req_dest,
   input  logic [DATA_W-1:0]      req_rt_old,
   input  logic                   mem_readdatavalid,
   input  logic [DATA_W-1:0]      mem_readdata,
   output logic                   wb_valid,
   input  logic                   wb_ready,
   output logic [4:0]             wb_dest,
   output logic [DATA_W-1:0]      wb_data,
   output logic                   wb_fault,
   output logic [$clog2(DEPTH):0] count,
   output logic                   err_spurious
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE  = (PTR_W + 1)'(1);

   localparam logic [2:0] OP_LW  = 3'd0;
   localparam logic [2:0] OP_LB  = 3'd1;
   localparam logic [2:0] OP_LBU = 3'd2;
   localparam logic [2:0] OP_LH  = 3'd3;
   localparam logic [2:0] OP_LHU = 3'd4;
   localparam logic [2:0] OP_LWL = 3'd5;
   localparam logic [2:0] OP_LWR = 3'd6;

   // Pointers carry one extra wrap bit so full and empty stay distinguishable
   // without a separate outstanding counter.
   logic [PTR_W:0]   head_x, ret_x, tail_x;
   logic [PTR_W-1:0] head_i, ret_i, tail_i;

   logic [2:0]        e_op   [DEPTH];
   logic [LANE_W-1:0] e_lane [DEPTH];
   logic [4:0]        e_dest [DEPTH];
   logic [31:0]       e_rt   [DEPTH];
   logic [DATA_W-1:0] e_raw  [DEPTH];
   logic [DEPTH-1:0]  e_ret;

   logic enq, ret_fire, pop, outstanding;

   assign head_i = head_x[PTR_W-1:0];
   assign ret_i  = ret_x[PTR_W-1:0];
   assign tail_i = tail_x[PTR_W-1:0];

   assign count       = tail_x - head_x;
   assign req_ready   = (count != FULL_CNT);
   assign outstanding = (ret_x != tail_x);
   assign enq         = req_valid & req_ready;
   assign ret_fire    = mem_readdatavalid & outstanding;
   assign pop         = wb_valid & wb_ready;

   // Pointer advance and sticky spurious-return flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_x       <= '0;
         ret_x        <= '0;
         tail_x       <= '0;
         err_spurious <= 1'b0;
      end else begin
         if (enq)
            tail_x <= tail_x + PTR_ONE;
         if (ret_fire)
            ret_x <= ret_x + PTR_ONE;
         if (pop)
            head_x <= head_x + PTR_ONE;
         if (mem_readdatavalid && !outstanding)
            err_spurious <= 1'b1;
      end
   end

   // Entry storage; enqueue, return and pop always address distinct slots.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            e_op[i]   <= '0;
            e_lane[i] <= '0;
            e_dest[i] <= '0;
            e_rt[i]   <= '0;
            e_raw[i]  <= '0;
         end
         e_ret <= '0;
      end else begin
         if (enq) begin
            e_op[tail_i]   <= req_op;
            e_lane[tail_i] <= req_lane;
            e_dest[tail_i] <= req_dest;
            e_rt[tail_i]   <= req_rt_old[31:0];
            e_ret[tail_i]  <= 1'b0;
         end
         if (ret_fire) begin
            e_raw[ret_i] <= mem_readdata;
            e_ret[ret_i] <= 1'b1;
         end
         if (pop) begin
            e_ret[head_i]  <= 1'b0;
            e_raw[head_i]  <= '0;
            e_op[head_i]   <= '0;
            e_lane[head_i] <= '0;
            e_dest[head_i] <= '0;
            e_rt[head_i]   <= '0;
         end
      end
   end

   logic [2:0]        h_op;
   logic [LANE_W-1:0] h_lane;
   logic [4:0]        h_dest;
   logic [31:0]       h_rt;
   logic [DATA_W-1:0] h_raw;
   logic [31:0]       word;
   logic [1:0]        k;

   assign h_op   = e_op[head_i];
   assign h_lane = e_lane[head_i];
   assign h_dest = e_dest[head_i];
   assign h_rt   = e_rt[head_i];
   assign h_raw  = e_raw[head_i];
   assign k      = h_lane[1:0];

   generate
      if (DATA_W == 32) begin : g_word32
         assign word = h_raw;
      end else begin : g_word64
         assign word = h_raw[32*int'(h_lane[LANE_W-1:2]) +: 32];
      end
   endgenerate

   logic [7:0]        byte_v;
   logic [15:0]       half_v;
   logic [4:0]        sh_hi, sh_lo;
   logic [5:0]        sh_msk;
   logic [31:0]       lwl_r, lwr_r;
   logic [DATA_W-1:0] res;
   logic              fault;

   // Lane extraction, extension and unaligned-word merge for the head entry.
   always_comb begin
      byte_v = word[8*k +: 8];
      half_v = word[16*k[1] +: 16];
      sh_hi  = {2'd3 - k, 3'b000};
      sh_lo  = {k, 3'b000};
      sh_msk = {{1'b0, k} + 3'd1, 3'b000};
      lwl_r  = (word << sh_hi) | (h_rt & (32'hFFFF_FFFF >> sh_msk));
      lwr_r  = (word >> sh_lo) | (h_rt & ~(32'hFFFF_FFFF >> sh_lo));
      res    = '0;
      fault  = 1'b0;
      case (h_op)
         OP_LW: begin
            if (k != 2'd0) fault = 1'b1;
            else           res = DATA_W'($signed(word));
         end
         OP_LB:  res = DATA_W'($signed(byte_v));
         OP_LBU: res = DATA_W'(byte_v);
         OP_LH: begin
            if (k[0]) fault = 1'b1;
            else      res = DATA_W'($signed(half_v));
         end
         OP_LHU: begin
            if (k[0]) fault = 1'b1;
            else      res = DATA_W'(half_v);
         end
         OP_LWL:  res = DATA_W'($signed(lwl_r));
         OP_LWR:  res = DATA_W'($signed(lwr_r));
         default: fault = 1'b1;
      endcase
   end

   assign wb_valid = e_ret[head_i];
   assign wb_dest  = wb_valid ? h_dest : 5'd0;
   assign wb_fault = wb_valid & fault;
   assign wb_data  = (wb_valid && !fault) ? res : '0;

endmodule

// File: tb/tb_load_writeback_buffer.sv
module tb_load_writeback_buffer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;

   logic        req_valid, req_ready, mem_rdv, wb_valid, wb_ready, wb_fault, err_spurious;
   logic [2:0]  req_op, count;
   logic [1:0]  req_lane;
   logic [4:0]  req_dest, wb_dest;
   logic [31:0] req_rt_old, mem_rd, wb_data;

   logic        x_req_valid, x_req_ready, x_mem_rdv, x_wb_valid, x_wb_ready, x_wb_fault, x_err;
   logic [2:0]  x_req_op, x_count;
   logic [2:0]  x_req_lane;
   logic [4:0]  x_req_dest, x_wb_dest;
   logic [63:0] x_req_rt_old, x_mem_rd, x_wb_data;

   load_writeback_buffer #(.DATA_W(32), .DEPTH(4)) dut32 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_lane(req_lane), .req_dest(req_dest), .req_rt_old(req_rt_old),
      .mem_readdatavalid(mem_rdv), .mem_readdata(mem_rd),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest),
      .wb_data(wb_data), .wb_fault(wb_fault), .count(count),
      .err_spurious(err_spurious)
   );

   load_writeback_buffer #(.DATA_W(64), .DEPTH(4)) dut64 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(x_req_valid), .req_ready(x_req_ready), .req_op(x_req_op),
      .req_lane(x_req_lane), .req_dest(x_req_dest), .req_rt_old(x_req_rt_old),
      .mem_readdatavalid(x_mem_rdv), .mem_readdata(x_mem_rd),
      .wb_valid(x_wb_valid), .wb_ready(x_wb_ready), .wb_dest(x_wb_dest),
      .wb_data(x_wb_data), .wb_fault(x_wb_fault), .count(x_count),
      .err_spurious(x_err)
   );

   typedef struct {
      logic [2:0]  op;
      logic [1:0]  lane;
      logic [4:0]  dest;
      logic [31:0] rt;
      logic [31:0] mem;
      logic [31:0] data;
      logic        fault;
   } vec_t;

   typedef struct {
      logic [4:0]  dest;
      logic [31:0] data;
      logic        fault;
   } exp_t;

   vec_t vecs [20];
   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, got dest %0d data %0h", tag, wb_dest, wb_data);
      end else begin
         e = sb.pop_front();
         check({tag, "_valid"}, 64'(wb_valid), 64'd1);
         check({tag, "_dest"},  64'(wb_dest),  64'(e.dest));
         check({tag, "_data"},  64'(wb_data),  64'(e.data));
         check({tag, "_fault"}, 64'(wb_fault), 64'(e.fault));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] words [4];

      vecs[0]  = '{3'd1, 2'd1, 5'd1,  32'h0,         32'h1234_80FF, 32'hFFFF_FF80, 1'b0};
      vecs[1]  = '{3'd4, 2'd2, 5'd2,  32'h0,         32'h8001_7FFF, 32'h0000_8001, 1'b0};
      vecs[2]  = '{3'd3, 2'd1, 5'd3,  32'h0,         32'h8001_7FFF, 32'h0000_0000, 1'b1};
      vecs[3]  = '{3'd5, 2'd1, 5'd4,  32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD, 1'b0};
      vecs[4]  = '{3'd6, 2'd2, 5'd5,  32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_1122, 1'b0};
      vecs[5]  = '{3'd0, 2'd0, 5'd6,  32'h0,         32'h8765_4321, 32'h8765_4321, 1'b0};
      vecs[6]  = '{3'd0, 2'd2, 5'd7,  32'h0,         32'h8765_4321, 32'h0000_0000, 1'b1};
      vecs[7]  = '{3'd7, 2'd0, 5'd8,  32'h0,         32'h8765_4321, 32'h0000_0000, 1'b1};
      vecs[8]  = '{3'd2, 2'd3, 5'd9,  32'h0,         32'h9A00_0000, 32'h0000_009A, 1'b0};
      vecs[9]  = '{3'd1, 2'd0, 5'd10, 32'h0,         32'h0000_007F, 32'h0000_007F, 1'b0};
      vecs[10] = '{3'd3, 2'd2, 5'd11, 32'h0,         32'hF00D_1234, 32'hFFFF_F00D, 1'b0};
      vecs[11] = '{3'd5, 2'd3, 5'd12, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344, 1'b0};
      vecs[12] = '{3'd5, 2'd0, 5'd13, 32'hAABB_CCDD, 32'h1122_3344, 32'h44BB_CCDD, 1'b0};
      vecs[13] = '{3'd6, 2'd0, 5'd14, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344, 1'b0};
      vecs[14] = '{3'd6, 2'd3, 5'd15, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CC11, 1'b0};
      vecs[15] = '{3'd5, 2'd2, 5'd16, 32'hAABB_CCDD, 32'h1122_3344, 32'h2233_44DD, 1'b0};
      vecs[16] = '{3'd6, 2'd1, 5'd17, 32'hAABB_CCDD, 32'h1122_3344, 32'hAA11_2233, 1'b0};
      vecs[17] = '{3'd4, 2'd0, 5'd18, 32'h0,         32'h8001_7FFF, 32'h0000_7FFF, 1'b0};
      vecs[18] = '{3'd3, 2'd0, 5'd19, 32'h0,         32'h0000_8001, 32'hFFFF_8001, 1'b0};
      vecs[19] = '{3'd2, 2'd1, 5'd20, 32'h0,         32'h1234_80FF, 32'h0000_0080, 1'b0};

      words[0] = 32'hA000_0001;
      words[1] = 32'hB000_0002;
      words[2] = 32'hC000_0003;
      words[3] = 32'hD000_0004;

      req_valid = 0; req_op = 0; req_lane = 0; req_dest = 0; req_rt_old = 0;
      mem_rdv = 0; mem_rd = 0; wb_ready = 0;
      x_req_valid = 0; x_req_op = 0; x_req_lane = 0; x_req_dest = 0; x_req_rt_old = 0;
      x_mem_rdv = 0; x_mem_rd = 0; x_wb_ready = 0;

      // Reset values
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #2;
      check("rst_wb_valid",  64'(wb_valid),     64'd0);
      check("rst_req_ready", 64'(req_ready),    64'd1);
      check("rst_count",     64'(count),        64'd0);
      check("rst_wb_fault",  64'(wb_fault),     64'd0);
      check("rst_wb_data",   64'(wb_data),      64'd0);
      check("rst_wb_dest",   64'(wb_dest),      64'd0);
      check("rst_err",       64'(err_spurious), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Table-driven single loads: issue, return next cycle, writeback at N+1
      for (int i = 0; i < 20; i++) begin
         req_valid = 1; req_op = vecs[i].op; req_lane = vecs[i].lane;
         req_dest = vecs[i].dest; req_rt_old = vecs[i].rt;
         sb.push_back('{vecs[i].dest, vecs[i].data, vecs[i].fault});
         @(negedge clk);
         req_valid = 0;
         check($sformatf("vec%0d_count_issued", i), 64'(count), 64'd1);
         check($sformatf("vec%0d_pre_return_valid", i), 64'(wb_valid), 64'd0);
         mem_rdv = 1; mem_rd = vecs[i].mem;
         @(negedge clk);
         mem_rdv = 0;
         pop_check($sformatf("vec%0d", i));
         wb_ready = 1;
         @(negedge clk);
         wb_ready = 0;
         check($sformatf("vec%0d_count_after_pop", i), 64'(count), 64'd0);
      end

      // Fill to DEPTH with writeback stalled, extra request must be ignored
      wb_ready = 0;
      for (int i = 0; i < 4; i++) begin
         req_valid = 1; req_op = 3'd0; req_lane = 2'd0; req_dest = 5'(10 + i); req_rt_old = 0;
         sb.push_back('{5'(10 + i), words[i], 1'b0});
         @(negedge clk);
      end
      req_valid = 0;
      check("full_count", 64'(count), 64'd4);
      check("full_req_ready", 64'(req_ready), 64'd0);
      req_valid = 1; req_dest = 5'd31;
      for (int i = 0; i < 4; i++) begin
         mem_rdv = 1; mem_rd = words[i];
         @(negedge clk);
      end
      mem_rdv = 0; req_valid = 0;
      check("full_count_after_returns", 64'(count), 64'd4);
      check("full_wb_valid", 64'(wb_valid), 64'd1);
      wb_ready = 1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("drain%0d_count", i), 64'(count), 64'(4 - i));
         pop_check($sformatf("drain%0d", i));
         @(negedge clk);
      end
      wb_ready = 0;
      check("drain_count_end", 64'(count), 64'd0);
      check("drain_wb_valid_end", 64'(wb_valid), 64'd0);

      // Enqueue and pop in the same cycle
      req_valid = 1; req_op = 3'd0; req_lane = 2'd0; req_dest = 5'd5;
      sb.push_back('{5'd5, 32'h5555_AAAA, 1'b0});
      @(negedge clk);
      req_valid = 0; mem_rdv = 1; mem_rd = 32'h5555_AAAA;
      @(negedge clk);
      mem_rdv = 0;
      check("same_cycle_count_before", 64'(count), 64'd1);
      req_valid = 1; req_dest = 5'd6;
      sb.push_back('{5'd6, 32'h6666_0000, 1'b0});
      wb_ready = 1;
      pop_check("same_cycle_pop");
      @(negedge clk);
      req_valid = 0; wb_ready = 0;
      check("same_cycle_count_after", 64'(count), 64'd1);
      check("same_cycle_wb_valid", 64'(wb_valid), 64'd0);
      mem_rdv = 1; mem_rd = 32'h6666_0000;
      @(negedge clk);
      mem_rdv = 0;
      pop_check("same_cycle_second");
      wb_ready = 1;
      @(negedge clk);
      wb_ready = 0;
      check("same_cycle_count_end", 64'(count), 64'd0);

      // Spurious return with nothing outstanding
      check("spur_err_before", 64'(err_spurious), 64'd0);
      mem_rdv = 1; mem_rd = 32'hDEAD_BEEF;
      @(negedge clk);
      mem_rdv = 0;
      check("spur_err_set", 64'(err_spurious), 64'd1);
      check("spur_wb_valid", 64'(wb_valid), 64'd0);
      check("spur_count", 64'(count), 64'd0);
      repeat (3) @(negedge clk);
      check("spur_err_sticky", 64'(err_spurious), 64'd1);

      // Reset with two loads pending, one of them already returned
      req_valid = 1; req_op = 3'd0; req_lane = 2'd0; req_dest = 5'd20;
      @(negedge clk);
      req_dest = 5'd21;
      @(negedge clk);
      req_valid = 0; mem_rdv = 1; mem_rd = 32'h1234_5678;
      @(negedge clk);
      mem_rdv = 0;
      check("prerst_count", 64'(count), 64'd2);
      check("prerst_wb_valid", 64'(wb_valid), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_wb_valid",  64'(wb_valid),     64'd0);
      check("midrst_req_ready", 64'(req_ready),    64'd1);
      check("midrst_count",     64'(count),        64'd0);
      check("midrst_wb_data",   64'(wb_data),      64'd0);
      check("midrst_wb_dest",   64'(wb_dest),      64'd0);
      check("midrst_wb_fault",  64'(wb_fault),     64'd0);
      check("midrst_err",       64'(err_spurious), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      mem_rdv = 1; mem_rd = 32'hCAFE_0000;
      @(negedge clk);
      mem_rdv = 0;
      check("postrst_err", 64'(err_spurious), 64'd1);
      check("postrst_wb_valid", 64'(wb_valid), 64'd0);
      check("postrst_count", 64'(count), 64'd0);

      // 64-bit bus: upper word selection and top-lane byte
      x_req_valid = 1; x_req_op = 3'd0; x_req_lane = 3'd4; x_req_dest = 5'd7;
      @(negedge clk);
      x_req_valid = 0; x_mem_rdv = 1; x_mem_rd = 64'h8000_0001_0000_0002;
      @(negedge clk);
      x_mem_rdv = 0;
      check("w64_lw_valid", 64'(x_wb_valid), 64'd1);
      check("w64_lw_dest",  64'(x_wb_dest),  64'd7);
      check("w64_lw_data",  x_wb_data,       64'hFFFF_FFFF_8000_0001);
      check("w64_lw_fault", 64'(x_wb_fault), 64'd0);
      x_wb_ready = 1;
      @(negedge clk);
      x_wb_ready = 0;
      x_req_valid = 1; x_req_op = 3'd2; x_req_lane = 3'd7; x_req_dest = 5'd8;
      @(negedge clk);
      x_req_valid = 0; x_mem_rdv = 1;
      @(negedge clk);
      x_mem_rdv = 0;
      check("w64_lbu_data", x_wb_data, 64'h0000_0000_0000_0080);
      x_wb_ready = 1;
      @(negedge clk);
      x_wb_ready = 0;
      x_req_valid = 1; x_req_op = 3'd1; x_req_lane = 3'd7; x_req_dest = 5'd9;
      @(negedge clk);
      x_req_valid = 0; x_mem_rdv = 1;
      @(negedge clk);
      x_mem_rdv = 0;
      check("w64_lb_data", x_wb_data, 64'hFFFF_FFFF_FFFF_FF80);
      x_wb_ready = 1;
      @(negedge clk);
      x_wb_ready = 0;
      check("w64_count_end", 64'(x_count), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
